// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types, command-byte layout and byte helpers for mem_pin_bridge
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_TURN  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_RESP  = 3'd6
    } state_e;

    localparam int CMD_WE_BIT    = 0;
    localparam int CMD_WSTRB_LSB = 4;
    localparam int WORD_BYTES    = 4;

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    // Byte idx of a 32-bit word, byte 0 being the least significant
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[8*idx +: 8];
    endfunction

    // Command byte: byte enables in the upper nibble, store flag in bit 0
    function automatic logic [7:0] cmd_byte(input logic we, input logic [3:0] wstrb);
        logic [7:0] c;
        c = 8'h00;
        c[CMD_WSTRB_LSB +: 4] = wstrb;
        c[CMD_WE_BIT]         = we;
        return c;
    endfunction

endpackage

// File: rtl/mem_bridge_watchdog.sv
// rtl/mem_bridge_watchdog.sv - WAIT-phase timeout counter, used only with MEM_BRIDGE_TIMEOUT_EN
module mem_bridge_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ack_i,
    output logic expire_o
);

    // Expire fires in the WAIT cycle whose increment would make the count reach the limit,
    // so the response follows exactly TIMEOUT_CYCLES silent WAIT cycles after entry.
    localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear outside WAIT (so entry starts at zero) and on each ack; count silent WAIT cycles
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (!active_i || ack_i) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d    = cnt_q + 16'd1;
            expire_o = (cnt_q == LIMIT_M1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_pin_bridge.sv
// rtl/mem_pin_bridge.sv - byte-serial core-to-uio memory bridge; optional watchdog via MEM_BRIDGE_TIMEOUT_EN
import mem_bridge_pkg::*;

module mem_pin_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  bus_out,
    output logic [7:0]  bus_oe,
    input  logic [7:0]  bus_in,
    output logic        strobe,
    input  logic        ack_in
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_pin_bridge: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wd_expire;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    mem_bridge_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active_i (state_q == ST_WAIT),
        .ack_i    (ack_in),
        .expire_o (wd_expire)
    );

    logic err_q;

    // Latch the timeout flag on every entry to RESP so it is stable for the response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_WAIT && state_d == ST_RESP) begin
            err_q <= wd_expire;
        end
    end

    assign rsp_err = err_q;
`else
    assign wd_expire = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Next-state logic: request capture, byte sequencing and read-byte assembly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    wstrb_d = req_wstrb & {4{req_we}};
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_d   = 2'd0;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = we_q ? ST_WDATA : ST_TURN;
                end
            end
            ST_WDATA: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                cnt_d   = 2'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ack_in) begin
                    if (we_q) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0:    rbuf_d[7:0]   = bus_in;
                            2'd1:    rbuf_d[15:8]  = bus_in;
                            2'd2:    rbuf_d[23:16] = bus_in;
                            default: begin
                                rdata_d = {bus_in, rbuf_q};
                                state_d = ST_RESP;
                            end
                        endcase
                    end
                end else if (wd_expire) begin
                    rbuf_d  = 24'd0;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin and handshake outputs decoded from the current state only
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        strobe    = 1'b0;
        bus_out   = 8'h00;
        bus_oe    = 8'h00;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_CMD: begin
                strobe  = 1'b1;
                bus_oe  = 8'hFF;
                bus_out = cmd_byte(we_q, wstrb_q);
            end
            ST_ADDR: begin
                strobe  = 1'b1;
                bus_oe  = 8'hFF;
                bus_out = word_byte(addr_q, cnt_q);
            end
            ST_WDATA: begin
                strobe  = 1'b1;
                bus_oe  = 8'hFF;
                bus_out = word_byte(wdata_q, cnt_q);
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rsp_rdata = rdata_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 24'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
